// File: rtl/alu_sweep_driver.sv
// Exhaustive self-test initiator for the 4-bit signed ALU: sweeps all {a,b,sel}
// vectors, checks y against a golden model, and records error count and first failure.
// Optional macro ALU_SWEEP_LOGIC_MASK_EN: logic-mode compares only alu_y[3:0].
`timescale 1ns/1ps
module alu_sweep_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [5:0]  alu_y,
  output logic        busy,
  output logic        done,
  output logic [12:0] err_count,
  output logic        first_err_valid,
  output logic [11:0] first_err_vec,
  output logic [5:0]  first_err_y
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t        state_q, state_d;
  logic [11:0]   idx_q, idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [11:0]   vec_q, vec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [12:0]   err_q, err_d;
  logic          fev_valid_q, fev_valid_d;
  logic [11:0]   fev_vec_q, fev_vec_d;
  logic [5:0]    fev_y_q, fev_y_d;

  logic [5:0]    expected;
  logic          mismatch;

  function automatic logic [5:0] golden(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] sel);
    logic [5:0] sa;
    logic [5:0] sb;
    logic [3:0] r;
    logic [5:0] res;
    sa  = {{2{a[3]}}, a};
    sb  = {{2{b[3]}}, b};
    r   = '0;
    res = '0;
    if (!sel[3]) begin
      case (sel[2:0])
        3'd0: res = sa + 6'd1;
        3'd1: res = sa - 6'd1;
        3'd2: res = {sa[4:0], 1'b0};
        3'd3: res = sb + 6'd1;
        3'd4: res = sb - 6'd1;
        3'd5: res = {sb[4:0], 1'b0};
        3'd6: res = sa + sb;
        default: res = {sa[3:0], 2'b00};
      endcase
    end else begin
      case (sel[2:0])
        3'd0: r = ~a;
        3'd1: r = ~b;
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = a ~^ b;
        3'd6: r = ~(a & b);
        default: r = ~(a | b);
      endcase
      res = {2'b00, r};
    end
    return res;
  endfunction

  // The driven vector register always equals idx_q while a vector is applied.
  assign expected = golden(vec_q[11:8], vec_q[7:4], vec_q[3:0]);

`ifdef ALU_SWEEP_LOGIC_MASK_EN
  assign mismatch = vec_q[3] ? (alu_y[3:0] != expected[3:0]) : (alu_y != expected);
`else
  assign mismatch = (alu_y != expected);
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    fev_valid_d = fev_valid_q;
    fev_vec_d   = fev_vec_q;
    fev_y_d     = fev_y_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = DRIVE;
          idx_d       = '0;
          settle_d    = '0;
          vec_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = '0;
          fev_valid_d = 1'b0;
          fev_vec_d   = '0;
          fev_y_d     = '0;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 13'd1;
          if (!fev_valid_q) begin
            fev_valid_d = 1'b1;
            fev_vec_d   = idx_q;
            fev_y_d     = alu_y;
          end
        end
        if (idx_q == 12'hFFF) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 12'd1;
          vec_d   = idx_q + 12'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      settle_q    <= '0;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      fev_valid_q <= 1'b0;
      fev_vec_q   <= '0;
      fev_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fev_valid_q <= fev_valid_d;
      fev_vec_q   <= fev_vec_d;
      fev_y_q     <= fev_y_d;
    end
  end

  assign alu_a           = vec_q[11:8];
  assign alu_b           = vec_q[7:4];
  assign alu_sel         = vec_q[3:0];
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_valid_q;
  assign first_err_vec   = fev_vec_q;
  assign first_err_y     = fev_y_q;

endmodule
